alu_seq_unit: RTL and testbench

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_unit.sv | 179 +++++++++++++++++
 tb/tb_alu_seq_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: single-issue ALU with a valid/ready operand port and a
// valid/ready result port. Most opcodes finish in one cycle. MUL is an
// MSB-first shift-add that runs for WIDTH cycles. The result and flags are
// held until the consumer takes them.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its payload steady while valid is high. in_ready is
// high only in IDLE. out_valid is high only in HOLD.
module alu_seq_unit #(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [3:0]       ALUOpCode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultOut,
  output logic             zeroFlag,
  output logic             lessThanFlag,
  output logic             greaterThanFlag,
  output logic             carryFlag,
  output logic             overflowFlag,
  output logic             illegalOp,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

  state_t           state, state_nxt;
  logic             init_done;
  logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt;
  logic [3:0]       op_code;
  logic [SHW-1:0]   cnt;
  logic             accept, load;
  logic [WIDTH-1:0] cur_a, cur_b, alu_res, fin_res;
  logic [3:0]       cur_op;
  logic [SHW-1:0]   shamt;
  logic             alu_c, alu_v, alu_ill, cmp_lt, cmp_gt;

  assign accept = in_valid && in_ready;

  // The datapath sees the live inputs in IDLE (non-MUL ops finish on the
  // accept edge). Otherwise it sees the captured operands.
  assign cur_a  = (state == IDLE) ? data_in1  : op_a;
  assign cur_b  = (state == IDLE) ? data_in2  : op_b;
  assign cur_op = (state == IDLE) ? ALUOpCode : op_code;
  assign shamt  = cur_b[SHW-1:0];

  // MSB-first shift-add step: the bit index follows the down-counter.
  assign acc_nxt = {acc[WIDTH-2:0], 1'b0} + (op_b[cnt] ? op_a : '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (ALUOpCode == OP_MUL) ? BUSY : HOLD;
      BUSY:    if (cnt == '0) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state == IDLE) && init_done;
    out_valid = (state == HOLD);
    busy      = (state == BUSY);
    state_dbg = state;
  end

  // Single-cycle operations (MUL result comes from the accumulator instead)
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (cur_op)
      4'b0000: begin
        {alu_c, alu_res} = {1'b0, cur_a} + {1'b0, cur_b};
        alu_v = (cur_a[WIDTH-1] == cur_b[WIDTH-1]) && (alu_res[WIDTH-1] != cur_a[WIDTH-1]);
      end
      4'b0001: begin
        alu_res = cur_a - cur_b;
        alu_c   = (cur_a < cur_b);
        alu_v   = (cur_a[WIDTH-1] != cur_b[WIDTH-1]) && (alu_res[WIDTH-1] != cur_a[WIDTH-1]);
      end
      4'b0010: alu_res = cur_a & cur_b;
      4'b0011: alu_res = cur_a | cur_b;
      4'b0100: alu_res = cur_a ^ cur_b;
      4'b0101: alu_res = cur_a << shamt;
      4'b0110: alu_res = cur_a >> shamt;
      4'b0111: alu_res = $unsigned($signed(cur_a) >>> shamt);
      4'b1000: alu_res = {{(WIDTH-1){1'b0}}, ($signed(cur_a) < $signed(cur_b))};
      4'b1001: alu_res = {{(WIDTH-1){1'b0}}, (cur_a < cur_b)};
      4'b1010: alu_res = '0;
      default: begin
        alu_res = cur_a + cur_b;
        alu_ill = 1'b1;
      end
    endcase
  end

  // Operand compare, independent of opcode
  always_comb begin
    if (SIGNED_CMP) begin
      cmp_lt = $signed(cur_a) < $signed(cur_b);
      cmp_gt = $signed(cur_a) > $signed(cur_b);
    end else begin
      cmp_lt = cur_a < cur_b;
      cmp_gt = cur_a > cur_b;
    end
  end

  assign load    = (accept && (ALUOpCode != OP_MUL)) || ((state == BUSY) && (cnt == '0));
  assign fin_res = (state == BUSY) ? acc_nxt : alu_res;

  // Power-up gate so in_ready rises one edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  // Operand capture and multiplier iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      op_code <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else if (accept) begin
      op_a    <= data_in1;
      op_b    <= data_in2;
      op_code <= ALUOpCode;
      acc     <= '0;
      cnt     <= SHW'(WIDTH - 1);
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      cnt <= cnt - SHW'(1);
    end
  end

  // Result/flag registers, written only when an operation completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultOut       <= '0;
      zeroFlag        <= 1'b0;
      lessThanFlag    <= 1'b0;
      greaterThanFlag <= 1'b0;
      carryFlag       <= 1'b0;
      overflowFlag    <= 1'b0;
      illegalOp       <= 1'b0;
    end else if (load) begin
      resultOut       <= fin_res;
      zeroFlag        <= (fin_res == '0);
      lessThanFlag    <= cmp_lt;
      greaterThanFlag <= cmp_gt;
      carryFlag       <= alu_c;
      overflowFlag    <= alu_v;
      illegalOp       <= alu_ill;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit (WIDTH=32). One unsigned-compare and one
// signed-compare instance share the same stimulus.
module tb_alu_seq_unit;

  localparam int W  = 32;
  localparam int EW = W + 8;

  logic         clk, rst_n, in_valid, out_ready;
  logic [W-1:0] data_in1, data_in2;
  logic [3:0]   ALUOpCode;

  logic         in_ready, out_valid, busy;
  logic [W-1:0] resultOut;
  logic         zeroFlag, lessThanFlag, greaterThanFlag, carryFlag, overflowFlag, illegalOp;
  logic [1:0]   state_dbg;

  logic         s_in_ready, s_out_valid, s_busy;
  logic [W-1:0] s_resultOut;
  logic         s_zero, s_lt, s_gt, s_carry, s_ovf, s_ill;
  logic [1:0]   s_state_dbg;

  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_unit #(.WIDTH(W), .SIGNED_CMP(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in1(data_in1), .data_in2(data_in2), .ALUOpCode(ALUOpCode),
    .out_valid(out_valid), .out_ready(out_ready), .resultOut(resultOut),
    .zeroFlag(zeroFlag), .lessThanFlag(lessThanFlag), .greaterThanFlag(greaterThanFlag),
    .carryFlag(carryFlag), .overflowFlag(overflowFlag), .illegalOp(illegalOp),
    .busy(busy), .state_dbg(state_dbg)
  );

  alu_seq_unit #(.WIDTH(W), .SIGNED_CMP(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .data_in1(data_in1), .data_in2(data_in2), .ALUOpCode(ALUOpCode),
    .out_valid(s_out_valid), .out_ready(out_ready), .resultOut(s_resultOut),
    .zeroFlag(s_zero), .lessThanFlag(s_lt), .greaterThanFlag(s_gt),
    .carryFlag(s_carry), .overflowFlag(s_ovf), .illegalOp(s_ill),
    .busy(s_busy), .state_dbg(s_state_dbg)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: {result, zero, lt_u, gt_u, carry, ovf, illegal, lt_s, gt_s}
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] op);
    logic [W:0]          w;
    logic signed [W:0]   sx;
    logic [2*W-1:0]      p;
    logic [W-1:0]        r;
    logic                c, v, ill;
    r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b}; r = w[W-1:0]; c = w[W];
        sx = $signed({a[W-1], a}) + $signed({b[W-1], b}); v = sx[W] ^ sx[W-1];
      end
      4'd1: begin
        r = a - b; c = (a < b);
        sx = $signed({a[W-1], a}) - $signed({b[W-1], b}); v = sx[W] ^ sx[W-1];
      end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << b[4:0];
      4'd6:  r = a >> b[4:0];
      4'd7:  r = $signed(a) >>> b[4:0];
      4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: begin p = {32'b0, a} * {32'b0, b}; r = p[W-1:0]; end
      default: begin r = a + b; ill = 1'b1; end
    endcase
    return {r, (r == 0), (a < b), (a > b), c, v, ill,
            ($signed(a) < $signed(b)), ($signed(a) > $signed(b))};
  endfunction

  function automatic logic [EW-1:0] obs();
    return {resultOut, zeroFlag, lessThanFlag, greaterThanFlag, carryFlag,
            overflowFlag, illegalOp, s_lt, s_gt};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Drive one operation, wait for the result, check it, optionally stall
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                        input int hold, input bit junk);
    int lat, busy_cnt;
    logic [EW-1:0] e;
    @(negedge clk);
    data_in1 = a; data_in2 = b; ALUOpCode = op; in_valid = 1'b1; out_ready = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    exp_q.push_back(model(a, b, op));
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in1 = $urandom; data_in2 = $urandom; ALUOpCode = 4'($urandom_range(0, 15));
    if (hold > 0) out_ready = 1'b0;
    lat = 1; busy_cnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), (op == 4'd10) ? 64'd33 : 64'd1);
    chk("busy_cycles", 64'(busy_cnt), (op == 4'd10) ? 64'd32 : 64'd0);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
    chk("result_flags", 64'(obs()), 64'(e));
    chk("result_s", 64'(s_resultOut), 64'(e[EW-1:8]));
    for (int i = 0; i < hold; i++) begin
      in_valid = junk; data_in1 = $urandom; ALUOpCode = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      chk("hold_outputs", 64'(obs()), 64'(e));
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    data_in1 = '0; data_in2 = '0; ALUOpCode = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", 64'(obs()), 64'd0);
    chk("reset_valid_busy", {62'd0, out_valid, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", 64'(in_ready), 64'd1);

    // Headline vectors
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 0, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 4'b0001, 0, 1'b0);
    run_op(32'h0001_0003, 32'h0000_0005, 4'b1010, 0, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0024, 4'b0111, 0, 1'b0);
    run_op(32'h0000_0002, 32'h0000_0003, 4'b1111, 0, 1'b0);
    // Boundaries: equal operands, shift amount with upper bits set, max shift
    run_op(32'h0000_0005, 32'h0000_0005, 4'b0001, 0, 1'b0);
    run_op(32'h0000_0001, 32'hFFFF_FFE1, 4'b0101, 0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_001F, 4'b0110, 0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1010, 0, 1'b0);

    // Every opcode with random operands
    for (int op = 0; op < 16; op++)
      run_op($urandom, $urandom, 4'(op), 0, 1'b0);

    // Consumer stall with competing input requests
    run_op(32'h1234_5678, 32'h0F0F_0F0F, 4'b0100, 10, 1'b1);

    // Reset in the middle of a multiply
    @(negedge clk);
    data_in1 = 32'd7; data_in2 = 32'd9; ALUOpCode = 4'b1010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("mid_mul_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_mul_reset_outputs", 64'(obs()), 64'd0);
    chk("mid_mul_reset_ctrl", {61'd0, out_valid, busy, in_ready}, 64'd0);
    chk("mid_mul_reset_state", 64'(state_dbg), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    chk("no_result_after_reset", 64'(seen), 64'd0);
    run_op(32'd7, 32'd9, 4'b1010, 0, 1'b0);
    run_op(32'hDEAD_0000, 32'h0000_BEEF, 4'b0011, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
